seq_mult: RTL and testbench

Unsigned shift-and-add sequential multiplier: two W-bit operands are captured on a start request, and a 2W-bit product is produced after W iteration cycles. It sits directly upstream of the binary-to-BCD converter. `product` drives the converter's `bin` input, instantiated with width 2W; for W=4 that is an 8-bit binary input and a 10-bit BCD output. A ready/start/done handshake lets a controller or bench sequence operations one at a time.

---
 rtl/seq_mult_if.sv | 30 +++
 rtl/seq_mult.sv | 105 ++++++++++
 tb/tb_seq_mult.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_if.sv
// Handshake and data bundle for the sequential multiplier.
// The controller side (master) drives start and the operands; the multiplier (slave) returns status and product.
interface seq_mult_if #(
    parameter int W = 4
);
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             ready;
    logic             done;
    logic [2*W-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  ready,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ready,
        output done,
        output product
    );
endinterface

// File: rtl/seq_mult.sv
// Unsigned shift-and-add sequential multiplier: W iteration cycles per product.
// ready/done are decoded from the state register; product is a dedicated register.
module seq_mult #(
    parameter int W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_mult_if.slave   bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic [W-1:0]     mcand_r;
    logic [2*W:0]     acc_r;
    logic [2*W:0]     acc_add_s;
    logic [2*W:0]     acc_shift_s;
    logic [2*W-1:0]   product_r;

    // Conditional add into the upper W+1 bits (carry kept), then logical shift right.
    always_comb begin
        acc_add_s = acc_r;
        if (acc_r[0]) begin
            acc_add_s[2*W:W] = acc_r[2*W:W] + {1'b0, mcand_r};
        end else begin
            acc_add_s[2*W:W] = acc_r[2*W:W];
        end
        acc_shift_s = acc_add_s >> 1;
    end

    // Next-state decode; the unused encoding falls back to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_s = S_BUSY;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_BUSY;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iteration datapath and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r   <= {W{1'b0}};
            acc_r     <= {(2*W+1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            product_r <= {(2*W){1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand_r <= bus.a;
                        acc_r   <= {{(W+1){1'b0}}, bus.b};
                        cnt_r   <= CW'(W - 1);
                    end
                end
                S_BUSY: begin
                    acc_r <= acc_shift_s;
                    if (cnt_r == {CW{1'b0}}) begin
                        product_r <= acc_shift_s[2*W-1:0];
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign bus.ready   = (state_r == S_IDLE);
    assign bus.done    = (state_r == S_DONE);
    assign bus.product = product_r;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult (W=4 and W=8 instances) with a product scoreboard queue.
module tb_seq_mult;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done4;
    int   done8;
    logic [31:0] sb[$];

    seq_mult_if #(.W(4)) bus4 ();
    seq_mult_if #(.W(8)) bus8 ();

    seq_mult #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    seq_mult #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus4.done === 1'b1) done4 <= done4 + 1;
        if (bus8.done === 1'b1) done8 <= done8 + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [9:0] bcd10(input logic [7:0] v);
        int h, t, o;
        h = int'(v) / 100;
        t = (int'(v) / 10) % 10;
        o = int'(v) % 10;
        return {h[1:0], t[3:0], o[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb.size() > 0) exp = sb.pop_front();
        else exp = 'x;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run4(input logic [3:0] ai, input logic [3:0] bi);
        int cyc;
        int d0;
        check("ready_before", 32'(bus4.ready), 32'd1);
        d0 = done4;
        bus4.a = ai;
        bus4.b = bi;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        sb.push_back(32'(ai) * 32'(bi));
        cyc = 0;
        while (bus4.done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency4", 32'(cyc), 32'd4);
        check_pop("product4", 32'(bus4.product));
        @(posedge clk); #1;
        check("done_once4", 32'(done4 - d0), 32'd1);
        check("ready_back4", 32'(bus4.ready), 32'd1);
        check("done_low4", 32'(bus4.done), 32'd0);
    endtask

    initial begin
        int d0;
        int cyc;
        int c;
        int t1;
        int t2;
        logic saw_ready;
        checks = 0;
        failures = 0;
        done4 = 0;
        done8 = 0;

        // Reset with random inputs applied
        rst_n = 1'b0;
        bus4.start = 1'(($urandom & 32'd1));
        bus4.a = 4'($urandom);
        bus4.b = 4'($urandom);
        bus8.start = 1'(($urandom & 32'd1));
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready4", 32'(bus4.ready), 32'd1);
        check("rst_done4", 32'(bus4.done), 32'd0);
        check("rst_product4", 32'(bus4.product), 32'd0);
        check("rst_product8", 32'(bus8.product), 32'd0);
        bus4.start = 1'b0;
        bus8.start = 1'b0;
        #3 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("idle_no_done4", 32'(done4), 32'd0);
        check("idle_no_done8", 32'(done8), 32'd0);
        check("idle_ready4", 32'(bus4.ready), 32'd1);

        // Corner values
        run4(4'd0, 4'd9);
        run4(4'd1, 4'd1);
        run4(4'd15, 4'd15);

        // Full sweep with BCD chaining spot check
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run4(4'(ai), 4'(bi));
                if (ai == 12 && bi == 13) begin
                    check("bcd_156", 32'(bcd10(bus4.product)), 32'(10'b01_0101_0110));
                end
            end
        end

        // Start ignored during BUSY and DONE
        d0 = done4;
        bus4.a = 4'd3;
        bus4.b = 4'd5;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        sb.push_back(32'd15);
        bus4.a = 4'd15;
        bus4.b = 4'd15;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        cyc = 1;
        while (bus4.done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ign_latency", 32'(cyc), 32'd4);
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        check("ign_ready", 32'(bus4.ready), 32'd1);
        check_pop("ign_product", 32'(bus4.product));
        repeat (6) @(posedge clk);
        #1;
        check("ign_single_done", 32'(done4 - d0), 32'd1);
        check("ign_product_hold", 32'(bus4.product), 32'd15);

        // Reset in the middle of an operation
        bus4.a = 4'd11;
        bus4.b = 4'd11;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        sb.push_back(32'd121);
        @(posedge clk); #1;
        @(posedge clk); #1;
        d0 = done4;
        rst_n = 1'b0;
        #1;
        check("abort_product", 32'(bus4.product), 32'd0);
        check("abort_ready", 32'(bus4.ready), 32'd1);
        check("abort_done", 32'(bus4.done), 32'd0);
        sb.delete();
        #3 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done4 - d0), 32'd0);
        check("abort_product_hold", 32'(bus4.product), 32'd0);
        run4(4'd11, 4'd11);

        // W=8 back-to-back with start held high
        bus8.a = 8'd255;
        bus8.b = 8'd255;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        sb.push_back(32'd65025);
        bus8.a = 8'd200;
        bus8.b = 8'd129;
        sb.push_back(32'd25800);
        c = 0;
        t1 = -1;
        t2 = -1;
        saw_ready = 1'b0;
        while (t2 < 0 && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (saw_ready) bus8.start = 1'b0;
            saw_ready = (bus8.ready === 1'b1) && bus8.start;
            if (bus8.done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = c;
                    check_pop("b2b_product1", 32'(bus8.product));
                end else begin
                    t2 = c;
                    check_pop("b2b_product2", 32'(bus8.product));
                end
            end else if (t1 >= 0) begin
                check("b2b_hold", 32'(bus8.product), 32'd65025);
            end
        end
        bus8.start = 1'b0;
        check("b2b_done2_seen", 32'(t2 >= 0), 32'd1);
        check("b2b_first_latency", 32'(t1), 32'd8);
        check("b2b_period", 32'(t2 - t1), 32'd10);
        @(posedge clk); #1;
        check("b2b_done_count", 32'(done8), 32'd2);
        check("b2b_ready_back", 32'(bus8.ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
